// File: rtl/sequenciador_operandos.sv
// Operand-entry and result-capture stage around the external 8-bit signed adder.
// Loads A then B on load strobe edges, then captures the sum, the flags and signed overflow.
module sequenciador_operandos #(
  parameter int NUM_BITS = 8,
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BITS-1:0] din,
  input  logic                load,
  input  logic                clear,
  output logic [NUM_BITS-1:0] a_out,
  output logic [NUM_BITS-1:0] b_out,
  input  logic [NUM_BITS-1:0] s_in,
  input  logic                z_in,
  input  logic                n_in,
  input  logic                p_in,
  output logic [NUM_BITS-1:0] s_reg,
  output logic                z_reg,
  output logic                n_reg,
  output logic                p_reg,
  output logic                ovf,
  output logic                done,
  output logic [1:0]          state_o,
  output logic [CNT_BITS-1:0] op_count
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    CALC   = 2'd2,
    SHOW   = 2'd3
  } state_t;

  state_t state, next_state;
  logic   load_q;
  logic   armed;
  logic   load_edge;

  // armed blocks a strobe already high at reset release until it has been seen low
  assign load_edge = load & ~load_q & armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_A;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = WAIT_A;
    end else begin
      case (state)
        WAIT_A: if (load_edge) next_state = WAIT_B;
        WAIT_B: if (load_edge) next_state = CALC;
        CALC:   next_state = SHOW;
        SHOW:   if (load_edge) next_state = WAIT_B;
        default: next_state = WAIT_A;
      endcase
    end
  end

  always_comb begin
    state_o = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q   <= 1'b0;
      armed    <= 1'b0;
      a_out    <= '0;
      b_out    <= '0;
      s_reg    <= '0;
      z_reg    <= 1'b0;
      n_reg    <= 1'b0;
      p_reg    <= 1'b0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      op_count <= '0;
    end else begin
      load_q <= load;
      if (!load) armed <= 1'b1;
      if (clear) begin
        a_out    <= '0;
        b_out    <= '0;
        s_reg    <= '0;
        z_reg    <= 1'b0;
        n_reg    <= 1'b0;
        p_reg    <= 1'b0;
        ovf      <= 1'b0;
        done     <= 1'b0;
        op_count <= '0;
      end else begin
        done <= 1'b0;
        case (state)
          WAIT_A, SHOW: if (load_edge) a_out <= din;
          WAIT_B:       if (load_edge) b_out <= din;
          CALC: begin
            s_reg    <= s_in;
            z_reg    <= z_in;
            n_reg    <= n_in;
            p_reg    <= p_in;
            ovf      <= (a_out[NUM_BITS-1] == b_out[NUM_BITS-1]) &&
                        (s_in[NUM_BITS-1] != a_out[NUM_BITS-1]);
            done     <= 1'b1;
            op_count <= op_count + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequenciador_operandos.sv
// Directed bench for sequenciador_operandos: vector table of operations plus
// hand-written sequences for held load, clear, reset mid-CALC and counter wrap.
module tb_sequenciador_operandos;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       load;
  logic       clear;
  logic [7:0] a_out, b_out, s_in, s_reg;
  logic       z_in, n_in, p_in;
  logic       z_reg, n_reg, p_reg, ovf, done;
  logic [1:0] state_o;
  logic [3:0] op_count;

  int checks = 0;
  int errors = 0;

  sequenciador_operandos #(.NUM_BITS(8), .CNT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load), .clear(clear),
    .a_out(a_out), .b_out(b_out), .s_in(s_in), .z_in(z_in), .n_in(n_in), .p_in(p_in),
    .s_reg(s_reg), .z_reg(z_reg), .n_reg(n_reg), .p_reg(p_reg), .ovf(ovf), .done(done),
    .state_o(state_o), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // external adder: wrapping sum, Z = zero, N = sign, P = even result
  always_comb begin
    s_in = a_out + b_out;
    z_in = (s_in == 8'h00);
    n_in = s_in[7];
    p_in = ~s_in[0];
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       z;
    logic       n;
    logic       p;
    logic       v;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    din  = v;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " a_out"}, a_out, 0);
    chk({tag, " b_out"}, b_out, 0);
    chk({tag, " s_reg"}, s_reg, 0);
    chk({tag, " flags"}, {z_reg, n_reg, p_reg, ovf}, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " op_count"}, op_count, 0);
    chk({tag, " state"}, state_o, 0);
  endtask

  logic [7:0] prev_s;
  logic [3:0] exp_cnt;

  initial begin
    tbl[0] = '{8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'h64, 8'h64, 8'hC8, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'h05, 8'hFB, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; din = 8'h00; load = 1'b0; clear = 1'b0;
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    tick(); tick();

    // table of complete operations, results held across the next A load
    prev_s  = 8'h00;
    exp_cnt = 4'd0;
    for (int unsigned i = 0; i < 7; i++) begin
      do_load(tbl[i].a);
      chk("A state", state_o, 1);
      chk("A a_out", a_out, tbl[i].a);
      chk("A s_reg held", s_reg, prev_s);
      do_load(tbl[i].b);
      exp_cnt = exp_cnt + 4'd1;
      chk("op b_out", b_out, tbl[i].b);
      chk("op s_reg", s_reg, tbl[i].s);
      chk("op z", z_reg, tbl[i].z);
      chk("op n", n_reg, tbl[i].n);
      chk("op p", p_reg, tbl[i].p);
      chk("op ovf", ovf, tbl[i].v);
      chk("op done", done, 1);
      chk("op state", state_o, 3);
      chk("op count", op_count, exp_cnt);
      tick();
      chk("done pulse end", done, 0);
      chk("show state", state_o, 3);
      prev_s = tbl[i].s;
    end

    // clear from SHOW, then load held high for 6 cycles gives a single edge
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_zero("clear show");
    din  = 8'h07;
    load = 1'b1;
    repeat (6) tick();
    chk("hold a_out", a_out, 8'h07);
    chk("hold state", state_o, 1);
    chk("hold b_out", b_out, 8'h00);
    load = 1'b0;
    tick();
    din  = 8'h02;
    load = 1'b1;
    tick();
    chk("hold b load", b_out, 8'h02);
    chk("hold calc", state_o, 2);
    load = 1'b0;
    tick();
    chk("hold s_reg", s_reg, 8'h09);
    chk("hold p", p_reg, 0);
    chk("hold count", op_count, 1);

    // clear together with a B-load edge in WAIT_B
    clear = 1'b1; tick(); clear = 1'b0;
    do_load(8'h11);
    chk("pre clear state", state_o, 1);
    din   = 8'h22;
    load  = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_zero("clear edge");
    tick();
    chk("clear held load state", state_o, 0);
    chk("clear held load a_out", a_out, 0);
    load = 1'b0;
    tick();

    // asynchronous reset in the middle of CALC
    do_load(8'h01);
    din  = 8'h02;
    load = 1'b1;
    tick();
    chk("mid calc state", state_o, 2);
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    tick();
    chk("reset no done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("load high at release state", state_o, 0);
    chk("load high at release a_out", a_out, 0);
    load = 1'b0;
    tick();
    tick();

    // 17 operations: counter wraps 15 -> 0 and ends at 1
    exp_cnt = 4'd0;
    for (int unsigned i = 0; i < 17; i++) begin
      do_load(8'h01);
      do_load(8'h02);
      exp_cnt = exp_cnt + 4'd1;
      chk("wrap count", op_count, exp_cnt);
      chk("wrap s_reg", s_reg, 8'h03);
      if (i == 15) chk("wrap to zero", op_count, 0);
    end
    chk("wrap final", op_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
